seq_arith_unit: RTL and testbench

- Parametrised, clocked successor to the 4-bit combinational arithmetic block.
- Operands are WIDTH bits wide. Results are registered, with a valid/ready handshake on both the input and output sides.
- Multiply and divide are multi-cycle (shift-add and restoring, one bit per cycle). All other ops complete in one cycle.
- Sits between the operand register file and the ALSU result mux, replacing the fixed 4-bit arithmetic path.

---
 rtl/seq_arith_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_seq_arith_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_arith_unit.sv
// seq_arith_unit: clocked arithmetic unit with valid/ready on both sides.
// Single-cycle ops: ADD SUB INC DEC ASL ASR REV PAR, DIV by zero, illegal.
// Multi-cycle ops: MUL (shift-add) and DIV (restoring), one bit per cycle.
// Optional macro ARITH_SAT_EN: saturate ADD/INC on carry and SUB/DEC on borrow.
module seq_arith_unit #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             In_Valid,
   output logic             In_Ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       Op,
   output logic             Out_Valid,
   input  logic             Out_Ready,
   output logic [WIDTH-1:0] Out,
   output logic [WIDTH-1:0] Out_High,
   output logic             Carry_Out,
   output logic             Negative_Sign_Flag,
   output logic             Zero_Flag,
   output logic             Div_By_Zero,
   output logic             Illegal_Op
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_DIV = 4'd3;
   localparam logic [3:0] OP_INC = 4'd4;
   localparam logic [3:0] OP_DEC = 4'd5;
   localparam logic [3:0] OP_ASL = 4'd6;
   localparam logic [3:0] OP_ASR = 4'd7;
   localparam logic [3:0] OP_REV = 4'd8;
   localparam logic [3:0] OP_PAR = 4'd9;
   localparam logic [WIDTH-1:0] SH_LIM = WIDTH'(WIDTH);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

   state_t                 r_state, w_next;
   logic [CNT_W-1:0]       r_cnt;
   logic [2*WIDTH-1:0]     r_work;
   logic [WIDTH-1:0]       r_opnd;
   logic                   r_is_div;
   logic [WIDTH-1:0]       r_out, r_out_high;
   logic                   r_carry, r_neg, r_zero, r_dbz, r_ill;

   logic                   w_accept, w_multi;
   logic [WIDTH:0]         w_add, w_sub, w_inc;
   logic [WIDTH-1:0]       w_dec, w_rev;
   logic signed [WIDTH-1:0] w_a_s;
   logic [WIDTH-1:0]       w_res, w_res_hi;
   logic                   w_carry, w_neg, w_dbz, w_ill, w_zero;
   logic [WIDTH:0]         w_mul_sum, w_rem_sh;
   logic [WIDTH-1:0]       w_rem_diff;
   logic [2*WIDTH-1:0]     w_step;

`ifdef ARITH_SAT_EN
   // Clamp to all ones (to_max) or to zero when the operation overflowed.
   function automatic logic [WIDTH-1:0] sat_clamp(input logic [WIDTH-1:0] val,
                                                  input logic ovf, input logic to_max);
      if (!ovf) return val;
      return to_max ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
   endfunction
`endif

   assign w_accept = In_Valid && In_Ready;
   assign w_multi  = (Op == OP_MUL) || ((Op == OP_DIV) && (B != '0));
   assign w_add    = {1'b0, A} + {1'b0, B};
   assign w_sub    = {1'b0, A} - {1'b0, B};
   assign w_inc    = {1'b0, A} + (WIDTH+1)'(1);
   assign w_dec    = A - WIDTH'(1);
   assign w_a_s    = A;

   // Bit-reverse of operand A.
   always_comb begin
      w_rev = '0;
      for (int i = 0; i < WIDTH; i++) w_rev[i] = A[WIDTH-1-i];
   end

   // Single-cycle result and flags, computed straight from the input operands.
   always_comb begin
      w_res    = '0;
      w_res_hi = '0;
      w_carry  = 1'b0;
      w_neg    = 1'b0;
      w_dbz    = 1'b0;
      w_ill    = 1'b0;
      case (Op)
         OP_ADD: begin
            w_carry = w_add[WIDTH];
`ifdef ARITH_SAT_EN
            w_res = sat_clamp(w_add[WIDTH-1:0], w_add[WIDTH], 1'b1);
`else
            w_res = w_add[WIDTH-1:0];
`endif
         end
         OP_SUB: begin
            w_neg = w_sub[WIDTH];
`ifdef ARITH_SAT_EN
            w_res = sat_clamp(w_sub[WIDTH-1:0], w_sub[WIDTH], 1'b0);
`else
            w_res = w_sub[WIDTH-1:0];
`endif
         end
         OP_INC: begin
            w_carry = w_inc[WIDTH];
`ifdef ARITH_SAT_EN
            w_res = sat_clamp(w_inc[WIDTH-1:0], w_inc[WIDTH], 1'b1);
`else
            w_res = w_inc[WIDTH-1:0];
`endif
         end
         OP_DEC: begin
            w_neg = (A == '0);
`ifdef ARITH_SAT_EN
            w_res = sat_clamp(w_dec, (A == '0), 1'b0);
`else
            w_res = w_dec;
`endif
         end
         OP_MUL: w_res = '0;
         OP_DIV: begin
            // Only reaches the output registers when B is zero.
            w_res    = '1;
            w_res_hi = A;
            w_dbz    = 1'b1;
         end
         OP_ASL: w_res = (B >= SH_LIM) ? '0 : (A << B);
         OP_ASR: w_res = (B >= SH_LIM) ? {WIDTH{A[WIDTH-1]}} : (w_a_s >>> B);
         OP_REV: w_res = w_rev;
         OP_PAR: w_res = {{(WIDTH-1){1'b0}}, ^A};
         default: w_ill = 1'b1;
      endcase
      w_zero = (w_res == '0) && (w_res_hi == '0);
   end

   // One iteration of shift-add multiply or restoring divide on the work register.
   always_comb begin
      w_mul_sum  = {1'b0, r_work[2*WIDTH-1:WIDTH]} + (r_work[0] ? {1'b0, r_opnd} : '0);
      w_rem_sh   = {r_work[2*WIDTH-1:WIDTH], r_work[WIDTH-1]};
      w_rem_diff = w_rem_sh[WIDTH-1:0] - r_opnd;
      if (r_is_div) begin
         if (w_rem_sh >= {1'b0, r_opnd})
            w_step = {w_rem_diff, r_work[WIDTH-2:0], 1'b1};
         else
            w_step = {w_rem_sh[WIDTH-1:0], r_work[WIDTH-2:0], 1'b0};
      end else begin
         w_step = {w_mul_sum, r_work[WIDTH-1:1]};
      end
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (!RST_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = w_multi ? S_CALC : S_DONE;
         S_CALC: if (r_cnt == CNT_W'(1)) w_next = S_DONE;
         S_DONE: begin
            if (w_accept)       w_next = w_multi ? S_CALC : S_DONE;
            else if (Out_Ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Handshake outputs; in DONE a new op may enter as the result retires.
   always_comb begin
      In_Ready  = 1'b0;
      Out_Valid = 1'b0;
      case (r_state)
         S_IDLE: In_Ready = 1'b1;
         S_DONE: begin
            In_Ready  = Out_Ready;
            Out_Valid = 1'b1;
         end
         default: In_Ready = 1'b0;
      endcase
   end

   // Operand capture, iteration and result registers.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         r_cnt      <= '0;
         r_work     <= '0;
         r_opnd     <= '0;
         r_is_div   <= 1'b0;
         r_out      <= '0;
         r_out_high <= '0;
         r_carry    <= 1'b0;
         r_neg      <= 1'b0;
         r_zero     <= 1'b0;
         r_dbz      <= 1'b0;
         r_ill      <= 1'b0;
      end else if (w_accept) begin
         r_is_div <= (Op == OP_DIV);
         if (w_multi) begin
            r_cnt  <= CNT_W'(WIDTH);
            r_opnd <= (Op == OP_MUL) ? A : B;
            r_work <= (Op == OP_MUL) ? {{WIDTH{1'b0}}, B} : {{WIDTH{1'b0}}, A};
         end else begin
            r_out      <= w_res;
            r_out_high <= w_res_hi;
            r_carry    <= w_carry;
            r_neg      <= w_neg;
            r_zero     <= w_zero;
            r_dbz      <= w_dbz;
            r_ill      <= w_ill;
         end
      end else if (r_state == S_CALC) begin
         r_work <= w_step;
         r_cnt  <= r_cnt - CNT_W'(1);
         if (r_cnt == CNT_W'(1)) begin
            r_out      <= w_step[WIDTH-1:0];
            r_out_high <= w_step[2*WIDTH-1:WIDTH];
            r_carry    <= 1'b0;
            r_neg      <= 1'b0;
            r_zero     <= (w_step == '0);
            r_dbz      <= 1'b0;
            r_ill      <= 1'b0;
         end
      end
   end

   assign Out                = r_out;
   assign Out_High           = r_out_high;
   assign Carry_Out          = r_carry;
   assign Negative_Sign_Flag = r_neg;
   assign Zero_Flag          = r_zero;
   assign Div_By_Zero        = r_dbz;
   assign Illegal_Op         = r_ill;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Scoreboard bench for seq_arith_unit at WIDTH=8. Inputs change 1ns after the
// rising edge; the monitor compares on the falling edge whenever a result is
// handed over (Out_Valid && Out_Ready).
module tb_seq_arith_unit;
   localparam logic [3:0] O_ADD = 4'd0, O_SUB = 4'd1, O_MUL = 4'd2, O_DIV = 4'd3,
                          O_INC = 4'd4, O_DEC = 4'd5, O_ASL = 4'd6, O_ASR = 4'd7,
                          O_REV = 4'd8, O_PAR = 4'd9;
`ifdef ARITH_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       CLK = 1'b0, RST_n = 1'b0, In_Valid = 1'b0, Out_Ready = 1'b0;
   logic [3:0] Op = '0;
   logic [7:0] A = '0, B = '0;
   logic       In_Ready, Out_Valid, Carry_Out, Negative_Sign_Flag, Zero_Flag, Div_By_Zero, Illegal_Op;
   logic [7:0] Out, Out_High;

   seq_arith_unit #(.WIDTH(8)) dut (
      .CLK(CLK), .RST_n(RST_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
      .A(A), .B(B), .Op(Op), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
      .Out(Out), .Out_High(Out_High), .Carry_Out(Carry_Out),
      .Negative_Sign_Flag(Negative_Sign_Flag), .Zero_Flag(Zero_Flag),
      .Div_By_Zero(Div_By_Zero), .Illegal_Op(Illegal_Op)
   );

   always #5 CLK = ~CLK;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [20:0] exp_q[$];
   string       name_q[$];
   logic [20:0] mon_exp;
   string       mon_name;
   logic [20:0] act;

   assign act = {Out, Out_High, Carry_Out, Negative_Sign_Flag, Zero_Flag, Div_By_Zero, Illegal_Op};

   // {Out, Out_High, Carry, Negative, Zero, DivByZero, Illegal}
   function automatic logic [20:0] mk(input logic [7:0] o, input logic [7:0] h,
                                      input logic c, input logic n, input logic z,
                                      input logic d, input logic i);
      return {o, h, c, n, z, d, i};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
      end
   endtask

   // Monitor: pop and compare on every handed-over result.
   always @(negedge CLK) begin
      if (RST_n && Out_Valid && Out_Ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_result: got 0x%0h with empty scoreboard", act);
         end else begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            chk(mon_name, 32'(act), 32'(mon_exp));
         end
      end
   end

   task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit push, input logic [20:0] e, input string nm);
      bit ok;
      int g;
      Op = op; A = a; B = b; In_Valid = 1'b1;
      if (push) begin
         exp_q.push_back(e);
         name_q.push_back(nm);
      end
      ok = 1'b0;
      g  = 0;
      while (!ok && g < 50) begin
         @(negedge CLK);
         ok = In_Ready;
         @(posedge CLK);
         #1;
         g++;
      end
      if (!ok) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout %s: In_Ready 0 required 1", nm);
      end
      In_Valid = 1'b0;
   endtask

   // Accept one op, then count cycles until Out_Valid; notes any In_Ready seen meanwhile.
   task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [20:0] e, input string nm, output int lat, output bit rdy);
      send(op, a, b, 1'b1, e, nm);
      lat = 1;
      rdy = 1'b0;
      while (!Out_Valid && lat < 40) begin
         if (In_Ready) rdy = 1'b1;
         @(posedge CLK);
         #1;
         lat++;
      end
   endtask

   initial begin
      int          lat;
      bit          rdy;
      bit          seen;
      logic [20:0] held;
      logic [7:0]  inc_a[4];
      logic [20:0] inc_e[4];
      int          g;

      // Reset, then make Out_Valid high, then reset again for 2 cycles.
      RST_n = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST_n = 1'b1;
      Out_Ready = 1'b0;
      send(O_ADD, 8'h01, 8'h02, 1'b0, '0, "preload");
      chk("pre_reset_valid", Out_Valid, 1);
      chk("pre_reset_out", Out, 8'h03);
      RST_n = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST_n = 1'b1;
      chk("reset_out_valid", Out_Valid, 0);
      chk("reset_outputs", 32'(act), 32'h0);
      chk("reset_in_ready", In_Ready, 1);

      Out_Ready = 1'b1;
      issue(O_ADD, 8'hF0, 8'h20, mk(SAT ? 8'hFF : 8'h10, 8'h00, 1, 0, 0, 0, 0), "add_carry", lat, rdy);
      chk("add_latency", lat, 1);
      issue(O_SUB, 8'h03, 8'h05, mk(SAT ? 8'h00 : 8'hFE, 8'h00, 0, 1, SAT, 0, 0), "sub_borrow", lat, rdy);
      issue(O_SUB, 8'h05, 8'h03, mk(8'h02, 8'h00, 0, 0, 0, 0, 0), "sub_plain", lat, rdy);
      issue(O_MUL, 8'hFF, 8'hFF, mk(8'h01, 8'hFE, 0, 0, 0, 0, 0), "mul_ff_ff", lat, rdy);
      chk("mul_latency", lat, 9);
      chk("mul_inready_calc", rdy, 0);
      issue(O_DIV, 8'd100, 8'd7, mk(8'd14, 8'd2, 0, 0, 0, 0, 0), "div_100_7", lat, rdy);
      chk("div_latency", lat, 9);
      issue(O_DIV, 8'd7, 8'd9, mk(8'd0, 8'd7, 0, 0, 0, 0, 0), "div_7_9", lat, rdy);
      issue(O_DIV, 8'd5, 8'd0, mk(8'hFF, 8'h05, 0, 0, 0, 1, 0), "div_by_zero", lat, rdy);
      chk("div0_latency", lat, 1);
      issue(O_ASR, 8'h80, 8'd9, mk(8'hFF, 8'h00, 0, 0, 0, 0, 0), "asr_big", lat, rdy);
      issue(O_ASR, 8'h40, 8'd1, mk(8'h20, 8'h00, 0, 0, 0, 0, 0), "asr_pos", lat, rdy);
      issue(O_ASL, 8'h81, 8'd1, mk(8'h02, 8'h00, 0, 0, 0, 0, 0), "asl_1", lat, rdy);
      issue(O_ASL, 8'h81, 8'd8, mk(8'h00, 8'h00, 0, 0, 1, 0, 0), "asl_full", lat, rdy);
      issue(O_REV, 8'h01, 8'h00, mk(8'h80, 8'h00, 0, 0, 0, 0, 0), "rev", lat, rdy);
      issue(O_PAR, 8'h07, 8'h00, mk(8'h01, 8'h00, 0, 0, 0, 0, 0), "par_odd", lat, rdy);
      issue(O_PAR, 8'h03, 8'h00, mk(8'h00, 8'h00, 0, 0, 1, 0, 0), "par_even", lat, rdy);
      issue(4'd12, 8'h12, 8'h34, mk(8'h00, 8'h00, 0, 0, 1, 0, 1), "illegal_op", lat, rdy);
      chk("illegal_latency", lat, 1);

      // Back-to-back INC stream: one accept per cycle while results retire.
      inc_a[0] = 8'h00; inc_e[0] = mk(8'h01, 8'h00, 0, 0, 0, 0, 0);
      inc_a[1] = 8'h7F; inc_e[1] = mk(8'h80, 8'h00, 0, 0, 0, 0, 0);
      inc_a[2] = 8'hFE; inc_e[2] = mk(8'hFF, 8'h00, 0, 0, 0, 0, 0);
      inc_a[3] = 8'hFF; inc_e[3] = mk(SAT ? 8'hFF : 8'h00, 8'h00, 1, 0, !SAT, 0, 0);
      Op = O_INC; B = 8'h00; In_Valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         A = inc_a[i];
         exp_q.push_back(inc_e[i]);
         name_q.push_back($sformatf("inc_stream_%0d", i));
         @(negedge CLK);
         chk($sformatf("stream_in_ready_%0d", i), In_Ready, 1);
         @(posedge CLK);
         #1;
         chk($sformatf("stream_out_valid_%0d", i), Out_Valid, 1);
      end
      In_Valid = 1'b0;
      @(negedge CLK);
      #1;
      chk("stream_drained", exp_q.size(), 0);
      @(posedge CLK);
      #1;

      // Consumer stall: result must hold and In_Ready must follow Out_Ready.
      Out_Ready = 1'b0;
      send(O_DEC, 8'h00, 8'h00, 1'b1, mk(SAT ? 8'h00 : 8'hFF, 8'h00, 0, 1, SAT, 0, 0), "dec_zero");
      held = act;
      chk("stall_first_valid", Out_Valid, 1);
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK);
         #1;
         chk($sformatf("stall_valid_%0d", i), Out_Valid, 1);
         chk($sformatf("stall_stable_%0d", i), 32'(act), 32'(held));
         chk($sformatf("stall_in_ready_%0d", i), In_Ready, 0);
      end
      Out_Ready = 1'b1;
      @(posedge CLK);
      #1;
      chk("stall_released", Out_Valid, 0);

      // Reset in the middle of a multiply aborts it.
      send(O_MUL, 8'h03, 8'h04, 1'b0, '0, "mul_abort");
      repeat (3) @(posedge CLK);
      #1 RST_n = 1'b0;
      @(posedge CLK);
      #1 RST_n = 1'b1;
      chk("abort_cleared", 32'(act), 32'h0);
      chk("abort_in_ready", In_Ready, 1);
      seen = 1'b0;
      repeat (15) begin
         @(posedge CLK);
         #1;
         if (Out_Valid) seen = 1'b1;
      end
      chk("abort_no_valid", seen, 0);

      g = 0;
      while (exp_q.size() != 0 && g < 50) begin
         @(posedge CLK);
         #1;
         g++;
      end
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
